// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache and D-cache.
// The granted request is latched at grant time and held until mem_ready.
module cache_mem_arbiter #(
  parameter int           ADDR_W = 32,
  parameter int           DATA_W = 32,
  parameter logic [1:0]   I_SIZE = 2'b10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   i_a,
  input  logic                i_strobe,
  output logic                i_ready,
  output logic [DATA_W-1:0]   i_data,
  input  logic [ADDR_W-1:0]   d_a,
  input  logic                d_strobe,
  input  logic                d_rw,
  input  logic [1:0]          d_size,
  input  logic [DATA_W/8-1:0] d_wen,
  input  logic [DATA_W-1:0]   d_st_data,
  output logic                d_ready,
  output logic [DATA_W-1:0]   d_data,
  output logic [ADDR_W-1:0]   mem_a,
  output logic                mem_access,
  output logic                mem_write,
  output logic [1:0]          mem_size,
  output logic [DATA_W/8-1:0] mem_sel,
  output logic [DATA_W-1:0]   mem_st_data,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                grant_i,
  output logic                grant_d
);
  localparam int BE_W = DATA_W/8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GNT_I = 2'd1;
  localparam logic [1:0] S_GNT_D = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              last_gnt_q, last_gnt_d;   // 0 = I, 1 = D
  logic [ADDR_W-1:0] a_q, a_d;
  logic              access_q, access_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic [BE_W-1:0]   sel_q, sel_d;
  logic [DATA_W-1:0] st_q, st_d;

  logic pick_i, pick_d;

  // On a tie, the cache not granted last wins.
  assign pick_i = i_strobe & (~d_strobe | last_gnt_q);
  assign pick_d = d_strobe & (~i_strobe | ~last_gnt_q);

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    a_d        = a_q;
    access_d   = access_q;
    write_d    = write_q;
    size_d     = size_q;
    sel_d      = sel_q;
    st_d       = st_q;
    case (state_q)
      S_IDLE: begin
        if (pick_i) begin
          state_d    = S_GNT_I;
          last_gnt_d = 1'b0;
          a_d        = i_a;
          access_d   = 1'b1;
          write_d    = 1'b0;
          size_d     = I_SIZE;
          sel_d      = '1;
          st_d       = '0;
        end else if (pick_d) begin
          state_d    = S_GNT_D;
          last_gnt_d = 1'b1;
          a_d        = d_a;
          access_d   = 1'b1;
          write_d    = d_rw;
          size_d     = d_size;
          sel_d      = d_wen;
          st_d       = d_st_data;
        end
      end
      S_GNT_I, S_GNT_D: begin
        if (mem_ready) begin
          state_d  = S_IDLE;
          access_d = 1'b0;
        end
      end
      default: begin
        state_d  = S_IDLE;
        access_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      last_gnt_q <= 1'b1;
      a_q        <= '0;
      access_q   <= 1'b0;
      write_q    <= 1'b0;
      size_q     <= '0;
      sel_q      <= '0;
      st_q       <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      a_q        <= a_d;
      access_q   <= access_d;
      write_q    <= write_d;
      size_q     <= size_d;
      sel_q      <= sel_d;
      st_q       <= st_d;
    end
  end

  assign grant_i     = (state_q == S_GNT_I);
  assign grant_d     = (state_q == S_GNT_D);
  assign i_ready     = mem_ready & grant_i;
  assign d_ready     = mem_ready & grant_d;
  assign i_data      = mem_data;
  assign d_data      = mem_data;
  assign mem_a       = a_q;
  assign mem_access  = access_q;
  assign mem_write   = write_q;
  assign mem_size    = size_q;
  assign mem_sel     = sel_q;
  assign mem_st_data = st_q;
endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Sequential arbiter between the instruction cache and the data cache for the single `axi_interface` memory port of `mycpu_top`. It takes over the current combinational instruction-first select. Each transaction is latched into registers at grant, and the grant is held until `mem_ready` so the downstream port sees stable signals. Ties are broken round-robin, so neither cache can starve the other.

## Interface
Parameters:
- `ADDR_W`, 32, width of addresses.
- `DATA_W`, 32, width of data; `DATA_W/8` is the width of the byte-enable signals.
- `I_SIZE`, 2'b10, transfer size driven for instruction fetches.

Ports:
- `clk`  in  1  single clock; all state is updated on the rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `i_a`  in  ADDR_W  instruction-cache fetch address.
- `i_strobe`  in  1  instruction-cache request; held high until `i_ready`.
- `i_ready`  out  1  instruction transaction complete.
- `i_data`  out  DATA_W  fetch data, valid when `i_ready` is high.
- `d_a`  in  ADDR_W  data-cache address.
- `d_strobe`  in  1  data-cache request; held high until `d_ready`.
- `d_rw`  in  1  0 = read, 1 = write.
- `d_size`  in  2  data transfer size.
- `d_wen`  in  DATA_W/8  data byte enables.
- `d_st_data`  in  DATA_W  store data.
- `d_ready`  out  1  data transaction complete.
- `d_data`  out  DATA_W  load data, valid when `d_ready` is high.
- `mem_a`  out  ADDR_W  downstream address (registered).
- `mem_access`  out  1  downstream request (registered).
- `mem_write`  out  1  downstream write flag (registered).
- `mem_size`  out  2  downstream size (registered).
- `mem_sel`  out  DATA_W/8  downstream byte enables (registered).
- `mem_st_data`  out  DATA_W  downstream store data (registered).
- `mem_ready`  in  1  single-cycle completion pulse from `axi_interface`.
- `mem_data`  in  DATA_W  downstream read data.
- `grant_i`, `grant_d`  out  1 each  current owner of the port; never both high.

## Operation
- State machine states: IDLE, GNT_I, GNT_D.
- Register `last_gnt` records which cache was granted last (0 = I, 1 = D).
- IDLE transitions:
  - `i_strobe` only: go to GNT_I.
  - `d_strobe` only: go to GNT_D.
  - Both high: grant the requester that was NOT granted last. `last_gnt` resets to D, so the instruction cache wins the first tie.
  - Neither high: stay in IDLE.
- On every grant edge:
  - Capture the `mem_*` output registers from the granted requester.
  - For the instruction cache: `mem_write`=0, `mem_size`=I_SIZE, `mem_sel`=all ones, `mem_st_data`=0.
  - For the data cache: `mem_write`=`d_rw`, `mem_size`=`d_size`, `mem_sel`=`d_wen`, `mem_st_data`=`d_st_data`.
  - Set `mem_access`=1 and update `last_gnt`.
- GNT_x:
  - Outputs stay frozen; requester inputs are ignored.
  - On a cycle with `mem_ready`=1, return to IDLE and clear `mem_access`.
  - If the granted requester drops its strobe before completion, the transaction still runs to completion. The ready pulse is still driven; the requester is responsible for ignoring it.
- Ready routing (combinational): `i_ready` = `mem_ready` & GNT_I; `d_ready` = `mem_ready` & GNT_D.
- Data routing: `i_data` = `d_data` = `mem_data`, passed through unregistered.
- `mem_ready` while in IDLE is ignored: no ready output, no state change.
- `grant_i` = (state == GNT_I); `grant_d` = (state == GNT_D).

## Timing
- Reset values:
  - State = IDLE, `last_gnt` = D.
  - `mem_access`, `mem_write`, `mem_a`, `mem_size`, `mem_sel`, `mem_st_data` all 0.
  - `grant_i`, `grant_d`, `i_ready`, `d_ready` all 0.
- Asserting `rst` mid-transaction forces all of the above immediately, without waiting for a clock edge. The in-flight request is dropped, and no ready pulse is produced for it.
- Grant latency: a strobe sampled high in IDLE at edge N gives `mem_access`=1 with latched fields from cycle N+1.
- Completion: `mem_ready` high in cycle M gives the requester's ready and data in cycle M (zero added latency). State is IDLE and `mem_access`=0 from M+1.
- Minimum of one IDLE bubble between transactions. The completing requester's strobe in cycle M is never re-sampled as a new request.
- Back-to-back with both strobes held: grants alternate I, D, I, D. Each transaction occupies its downstream latency plus one idle cycle.
- Simultaneous strobe assertion on the `mem_ready` cycle: the new request is not considered until IDLE at M+1.

## Test plan
- Reset, then `i_strobe`=1 with `i_a`=0xBFC00000, and `mem_ready` pulsed 3 cycles after the grant.
  - Next cycle: `mem_access`=1, `mem_a`=0xBFC00000, `mem_size`=2'b10, `mem_sel`=4'b1111, `mem_write`=0.
  - `i_ready`=1 with `i_data`=`mem_data`=0x24080001 in the `mem_ready` cycle.
- `d_strobe`=1 with `d_rw`=1, `d_a`=0x80001004, `d_wen`=4'b0011, `d_size`=2'b01, `d_st_data`=0x0000ABCD.
  - Expect the `mem_*` outputs to carry exactly those values.
  - Expect `d_ready` on `mem_ready` and `i_ready` to stay 0.
- Both strobes held continuously from reset, 4 completions.
  - Grant order I, D, I, D.
  - `grant_i` and `grant_d` never high together, with exactly one IDLE cycle between grants.
- Change `d_a` and `d_st_data` to 0xDEADBEEF mid-GNT_D.
  - `mem_a` and `mem_st_data` keep their grant-time values until completion.
- Pulse `mem_ready` while in IDLE.
  - No `i_ready` or `d_ready`, and the state stays IDLE.
- Assert `rst` for one cycle in GNT_D, before `mem_ready`.
  - `mem_access`=0 and `grant_d`=0 immediately, with no clock edge needed.
  - After release, a tie is granted to the instruction cache.
